inst_fetch: RTL

//  Instruction-fetch stage of the light_rv32i core; feeds o_IfInstr to decode, where imm_extend consumes it.
//  - Owns the PC register.
//  - Issues one outstanding request at a time to instruction memory.
//  - Holds each fetched word in a one-entry output buffer, handed to decode with a valid/ready handshake.
//  - Redirects the PC on branch/jump; instructions fetched on the old path are discarded.

---
 rtl/inst_fetch_pkg.sv | 9 +
 rtl/if_out_buf.sv | 37 +++
 rtl/inst_fetch.sv | 73 +++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: fetch FSM state encodings and instruction size shared by the fetch stage
package inst_fetch_pkg;
    typedef enum logic [1:0] {
        IF_ST_REQ   = 2'd0,
        IF_ST_WAIT  = 2'd1,
        IF_ST_DRAIN = 2'd2
    } if_state_t;
    localparam int INST_BYTES = 4;
endpackage

// File: rtl/if_out_buf.sv
// if_out_buf: one-entry valid/instr/pc buffer between fetch and decode
//  i_Clk, i_Rst  clock, sync active-high reset (empties and zeroes the entry)
//  i_Load        write {i_Instr, i_Pc} and mark valid
//  i_Clear       drop the entry (redirect)
//  i_Transfer    decode took the entry
//  o_Valid, o_Instr, o_Pc  the buffered entry
module if_out_buf #(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Load,
    input  logic                  i_Clear,
    input  logic                  i_Transfer,
    input  logic [INST_WIDTH-1:0] i_Instr,
    input  logic [ADDR_WIDTH-1:0] i_Pc,
    output logic                  o_Valid,
    output logic [INST_WIDTH-1:0] o_Instr,
    output logic [ADDR_WIDTH-1:0] o_Pc
);
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Valid <= 1'b0;
            o_Instr <= '0;
            o_Pc    <= '0;
        end else if (i_Clear) begin
            o_Valid <= 1'b0;
        end else if (i_Load) begin
            o_Valid <= 1'b1;
            o_Instr <= i_Instr;
            o_Pc    <= i_Pc;
        end else if (i_Transfer) begin
            o_Valid <= 1'b0;
        end
    end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: light_rv32i fetch stage; owns the PC, one outstanding imem request, redirect handling
//  i_Clk, i_Rst                       clock, sync active-high reset
//  o_ImemReq/o_ImemAddr/i_ImemGnt     request channel to instruction memory
//  i_ImemRvalid/i_ImemRdata           response channel
//  o_IfValid/o_IfInstr/o_IfPc/i_IdReady  handshake to decode
//  i_Redirect/i_RedirectPc            branch/jump target pulse
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                    INST_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    output logic                  o_ImemReq,
    output logic [ADDR_WIDTH-1:0] o_ImemAddr,
    input  logic                  i_ImemGnt,
    input  logic                  i_ImemRvalid,
    input  logic [INST_WIDTH-1:0] i_ImemRdata,
    output logic                  o_IfValid,
    output logic [INST_WIDTH-1:0] o_IfInstr,
    output logic [ADDR_WIDTH-1:0] o_IfPc,
    input  logic                  i_IdReady,
    input  logic                  i_Redirect,
    input  logic [ADDR_WIDTH-1:0] i_RedirectPc
);
    if_state_t             r_State;
    logic [ADDR_WIDTH-1:0] r_Pc;
    logic                  w_Bfree;
    logic                  w_Load;
    logic                  w_unused;
    assign w_unused   = ^i_RedirectPc[1:0];
    assign w_Bfree    = !o_IfValid || i_IdReady;
    assign o_ImemReq  = !i_Rst && r_State == IF_ST_REQ && w_Bfree && !i_Redirect;
    assign o_ImemAddr = r_Pc;
    // a response coinciding with a redirect belongs to the old path and is never buffered
    assign w_Load     = r_State == IF_ST_WAIT && i_ImemRvalid && !i_Redirect;
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State <= IF_ST_REQ;
            r_Pc    <= RESET_PC;
        end else if (i_Redirect) begin
            r_Pc    <= {i_RedirectPc[ADDR_WIDTH-1:2], 2'b00};
            // an outstanding request must still retire through DRAIN unless it returns now
            r_State <= (r_State == IF_ST_REQ || i_ImemRvalid) ? IF_ST_REQ : IF_ST_DRAIN;
        end else begin
            case (r_State)
                IF_ST_REQ:  if (o_ImemReq && i_ImemGnt) r_State <= IF_ST_WAIT;
                IF_ST_WAIT: if (i_ImemRvalid) begin
                    r_Pc    <= r_Pc + ADDR_WIDTH'(INST_BYTES);
                    r_State <= IF_ST_REQ;
                end
                default:    if (i_ImemRvalid) r_State <= IF_ST_REQ;
            endcase
        end
    end
    if_out_buf #(
        .INST_WIDTH(INST_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_buf (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Load     (w_Load),
        .i_Clear    (i_Redirect),
        .i_Transfer (o_IfValid && i_IdReady),
        .i_Instr    (i_ImemRdata),
        .i_Pc       (r_Pc),
        .o_Valid    (o_IfValid),
        .o_Instr    (o_IfInstr),
        .o_Pc       (o_IfPc)
    );
endmodule
